// File: rtl/rf_wb_pkg.sv
// ============================================================================
// rf_wb_pkg : shared widths, zero-register index and queue entry type for
//             the register-file write-back queue.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package rf_wb_pkg;

    localparam int RF_WB_ADDR_W = 4;
    localparam int RF_WB_DATA_W = 32;

    localparam logic [RF_WB_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [RF_WB_ADDR_W-1:0] addr;
        logic [RF_WB_DATA_W-1:0] data;
        logic                    valid;
    } rf_wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_addr_match.sv
// ============================================================================
// rf_wb_addr_match : compares one RD source index against the queued entries
//                    and the presented input; returns hit and youngest data.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module rf_wb_addr_match
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [RF_WB_ADDR_W-1:0] src,
    input  rf_wb_entry_t            entries [DEPTH],
    input  logic [PTR_W-1:0]        rd_ptr,
    input  logic                    in_valid,
    input  logic [RF_WB_ADDR_W-1:0] in_addr,
    input  logic [RF_WB_DATA_W-1:0] in_data,
    output logic                    hit,
    output logic [RF_WB_DATA_W-1:0] hit_data
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        // Walk head to tail so the last match seen is the youngest queued one.
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (entries[idx].valid && (entries[idx].addr == src)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
        if (in_valid && (in_addr == src)) begin
            hit      = 1'b1;
            hit_data = in_data;
        end
        if (src == ZERO_REG) begin
            hit      = 1'b0;
            hit_data = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_writeback_queue.sv
// ============================================================================
// rf_writeback_queue : in-order MT-stage result queue feeding the register
//                      file write port, with RD-stage RAW hazard detection.
//                      Optional forwarding enabled by RF_WB_FORWARD_EN.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module rf_writeback_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    // Must equal the entry struct widths in rf_wb_pkg.
    parameter int ADDR_W = RF_WB_ADDR_W,
    parameter int DATA_W = RF_WB_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         rf_busy,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    input  logic [ADDR_W-1:0]            rd_src1,
    input  logic [ADDR_W-1:0]            rd_src2,
    output logic                         hazard,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef RF_WB_FORWARD_EN
    ,
    output logic [DATA_W-1:0]            fwd1_data,
    output logic [DATA_W-1:0]            fwd2_data,
    output logic                         fwd1_hit,
    output logic                         fwd2_hit
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wb_entry_t       entries_q [DEPTH];
    rf_wb_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, enq, pop;
    logic               hit1, hit2;
    logic [DATA_W-1:0]  hit1_data, hit2_data;

    always_comb begin
        in_ready = rst && (count_q != CNT_W'(DEPTH));
        rf_we    = rst && (count_q != '0) && !rf_busy;
        rf_waddr = entries_q[rd_ptr_q].addr;
        rf_wdata = entries_q[rd_ptr_q].data;
        count    = count_q;
        push     = in_valid && in_ready;
        // Writes to the hardwired-zero register are accepted and dropped.
        enq      = push && (in_addr != ZERO_REG);
        pop      = rf_we;
    end

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (enq) begin
            entries_d[wr_ptr_q] = '{addr: in_addr, data: in_data, valid: 1'b1};
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    rf_wb_addr_match #(.DEPTH(DEPTH)) u_match1 (
        .src      (rd_src1),
        .entries  (entries_q),
        .rd_ptr   (rd_ptr_q),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hit      (hit1),
        .hit_data (hit1_data)
    );

    rf_wb_addr_match #(.DEPTH(DEPTH)) u_match2 (
        .src      (rd_src2),
        .entries  (entries_q),
        .rd_ptr   (rd_ptr_q),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hit      (hit2),
        .hit_data (hit2_data)
    );

`ifdef RF_WB_FORWARD_EN
    // Every match is forwarded, so RD never has to stall.
    always_comb begin
        fwd1_hit  = rst && hit1;
        fwd2_hit  = rst && hit2;
        fwd1_data = hit1_data;
        fwd2_data = hit2_data;
        hazard    = 1'b0;
    end
`else
    logic unused_hit_data;

    always_comb begin
        hazard          = rst && (hit1 || hit2);
        unused_hit_data = ^{hit1_data, hit2_data};
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
// ============================================================================
// tb_rf_writeback_queue : directed self-checking bench for rf_writeback_queue.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_rf_writeback_queue;

`ifdef RF_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_addr;
    logic [31:0] in_data;
    logic        rf_busy;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rd_src1;
    logic [3:0]  rd_src2;
    logic        hazard;
    logic [2:0]  count;
`ifdef RF_WB_FORWARD_EN
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic        fwd1_hit;
    logic        fwd2_hit;
`endif

    int vectors     = 0;
    int miscompares = 0;

    rf_writeback_queue #(.DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_busy  (rf_busy),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rd_src1  (rd_src1),
        .rd_src2  (rd_src2),
        .hazard   (hazard),
        .count    (count)
`ifdef RF_WB_FORWARD_EN
        ,
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_addr = 4'd3; in_data = 32'h0;
        rf_busy = 1'b0; rd_src1 = 4'd3; rd_src2 = 4'd0;
        #2;
        check("rst_count",    32'(count),    32'd0);
        check("rst_rf_we",    32'(rf_we),    32'd0);
        check("rst_hazard",   32'(hazard),   32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_waddr",    32'(rf_waddr), 32'd0);
        check("rst_wdata",    rf_wdata,      32'd0);

        next_cycle(); rst = 1'b1; in_valid = 1'b0; rd_src1 = 4'd0; #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single push, written the cycle after it is accepted.
        next_cycle(); in_valid = 1'b1; in_addr = 4'd3; in_data = 32'h0001_0000; #1;
        check("p1_no_bypass", 32'(rf_we), 32'd0);
        next_cycle(); in_valid = 1'b0; #1;
        check("p1_we",    32'(rf_we),    32'd1);
        check("p1_waddr", 32'(rf_waddr), 32'd3);
        check("p1_wdata", rf_wdata,      32'h0001_0000);
        check("p1_count", 32'(count),    32'd1);
        next_cycle(); #1;
        check("p1_empty", 32'(count), 32'd0);
        check("p1_idle",  32'(rf_we), 32'd0);

        // Fill under rf_busy: four accepted, fifth refused.
        rf_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); in_valid = 1'b1; in_addr = 4'(4 + i); in_data = 32'hA0 + 32'(i); #1;
            check($sformatf("fill_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        next_cycle(); in_valid = 1'b0; rd_src1 = 4'd7; #1;
        check("full_count",  32'(count),  32'd4);
        check("full_we",     32'(rf_we),  32'd0);
        check("haz_q7",      32'(hazard), FWD ? 32'd0 : 32'd1);
        rd_src1 = 4'd9; #1;
        check("haz_none",    32'(hazard), 32'd0);
        rd_src1 = 4'd0;
        next_cycle(); rf_busy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("drain_we%0d", j),    32'(rf_we),    32'd1);
            check($sformatf("drain_addr%0d", j),  32'(rf_waddr), 32'(4 + j));
            check($sformatf("drain_data%0d", j),  rf_wdata,      32'hA0 + 32'(j));
            next_cycle();
        end
        #1;
        check("drain_count", 32'(count), 32'd0);

        // Register-0 write is consumed and dropped; no hazard on src 0.
        next_cycle(); in_valid = 1'b1; in_addr = 4'd0; in_data = 32'hDEAD; rd_src1 = 4'd0; #1;
        check("r0_hazard", 32'(hazard),   32'd0);
        check("r0_ready",  32'(in_ready), 32'd1);
        next_cycle(); in_valid = 1'b0; #1;
        check("r0_count", 32'(count), 32'd0);
        check("r0_we",    32'(rf_we), 32'd0);

        // Hazard from the presented input, then from the queued copy.
        next_cycle(); in_valid = 1'b1; in_addr = 4'd9; in_data = 32'h99; rd_src2 = 4'd9; #1;
        check("haz_in", 32'(hazard), FWD ? 32'd0 : 32'd1);
        next_cycle(); in_valid = 1'b0; #1;
        check("haz_q9",   32'(hazard),   FWD ? 32'd0 : 32'd1);
        check("q9_waddr", 32'(rf_waddr), 32'd9);
        next_cycle(); rd_src2 = 4'd0; #1;
        check("q9_count", 32'(count), 32'd0);

        // Duplicate destinations drain in order.
        rf_busy = 1'b1;
        next_cycle(); in_valid = 1'b1; in_addr = 4'd2; in_data = 32'h11;
        next_cycle(); in_data = 32'h22;
        next_cycle(); in_valid = 1'b0; rd_src2 = 4'd2; #1;
        check("dup_count",  32'(count),  32'd2);
        check("dup_hazard", 32'(hazard), FWD ? 32'd0 : 32'd1);
`ifdef RF_WB_FORWARD_EN
        check("dup_fwd_hit",  32'(fwd2_hit), 32'd1);
        check("dup_fwd_data", fwd2_data,     32'h22);
        check("dup_fwd1_hit", 32'(fwd1_hit), 32'd0);
`endif
        next_cycle(); rf_busy = 1'b0; rd_src2 = 4'd0; #1;
        check("dup_w1", rf_wdata, 32'h11);
        check("dup_a1", 32'(rf_waddr), 32'd2);
        next_cycle(); #1;
        check("dup_w2", rf_wdata, 32'h22);
        check("dup_we2", 32'(rf_we), 32'd1);
        next_cycle(); #1;
        check("dup_done", 32'(count), 32'd0);

        // Reset in the middle of a drain discards everything.
        rf_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); in_valid = 1'b1; in_addr = 4'(10 + i); in_data = 32'hC0 + 32'(i);
        end
        next_cycle(); in_valid = 1'b0; #1;
        check("mid_count3", 32'(count), 32'd3);
        next_cycle(); rf_busy = 1'b0; #1;
        check("mid_we", 32'(rf_we), 32'd1);
        rst = 1'b0; #1;
        check("mid_rst_we",    32'(rf_we),    32'd0);
        check("mid_rst_count", 32'(count),    32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        next_cycle(); rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("post_rst_we%0d", k),    32'(rf_we), 32'd0);
            check($sformatf("post_rst_count%0d", k), 32'(count), 32'd0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-back end of the Euler pipeline register path. The RD stage reads register-file operands. This block collects results leaving the MT stage and writes them back into the register file, one entry per cycle, in program order.
- Small in-order queue with a valid/ready input, a register-file write port output, and a read-after-write hazard check on the RD stage's two source indices.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- ADDR_W, 4, register index width; matches the RD/MT register index fields.
- DATA_W, 32, fixed-point result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- in_valid  in  1  MT stage presents a result.
- in_ready  out  1  queue can accept a result.
- in_addr  in  ADDR_W  destination register index.
- in_data  in  DATA_W  result value.
- rf_busy  in  1  register-file write port is taken this cycle (host load); holds the write-back.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  ADDR_W  write index (head entry).
- rf_wdata  out  DATA_W  write data (head entry).
- rd_src1  in  ADDR_W  RD stage source index 1.
- rd_src2  in  ADDR_W  RD stage source index 2.
- hazard  out  1  a source index has a pending write; RD must stall.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, read and write pointers=0, every entry valid bit=0.
  - Outputs during reset: rf_we=0, hazard=0, in_ready=0.
  - Pending writes are discarded, including any reset mid-operation.
  - rf_waddr and rf_wdata are 0 after reset.
- After release, in_ready = (count != DEPTH). in_ready depends only on registered state, never on the same-cycle pop.
- Push happens when in_valid && in_ready.
  - If in_addr == 0 (register 0 is hardwired zero), the result is accepted but not enqueued: it is consumed and dropped.
- Pop: rf_we = (count != 0) && !rf_busy, combinational from head state.
  - rf_waddr and rf_wdata always show the head entry.
  - The head is retired on each rising edge where rf_we=1.
- Latency: an entry pushed at edge N can raise rf_we in the cycle after edge N at the earliest. There is no push-to-write bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a pop does not allow a same-cycle push, because in_ready is already 0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Duplicate destinations may coexist in the queue. They are written in order, so the youngest value lands last.
- hazard = (match(rd_src1) || match(rd_src2)), combinational.
  - match(x) is true when x != 0 and x equals either the address of any valid queued entry, or in_addr while in_valid=1, whether or not in_ready is high.
- rf_busy held high indefinitely: the queue fills, in_ready drops, and no entry is lost or reordered.

Optional Feature:
- Macro: RF_WB_FORWARD_EN.
- Defined:
  - Adds ports fwd1_data and fwd2_data (out, DATA_W) and fwd1_hit and fwd2_hit (out, 1).
  - fwdN_hit is set when rd_srcN matches. fwdN_data is the youngest match; the presented input counts as youngest, then queued entries from tail toward head.
  - hazard is driven 0 whenever a hit exists.
- Undefined: forwarding ports are absent and hazard behaves exactly as above.

Decomposition:
- Package rf_wb_pkg: default ADDR_W and DATA_W, ZERO_REG=0, and the entry struct typedef (addr, data, valid).
- One sub-module, rf_wb_addr_match. It takes a source index and the entry array plus the presented input, and returns hit and youngest data. It is instantiated twice, once per RD source.

Test Plan:
- Reset then idle: rst=0 -> count=0, rf_we=0, hazard=0. Release -> in_ready=1.
- Push addr 3 data 0x00010000 with rf_busy=0 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x00010000, then count returns to 0.
- rf_busy=1, push 5 results on consecutive cycles -> 4 accepted, in_ready=0 on the 5th. Drop rf_busy -> writes come out in order on 4 consecutive cycles.
- Queue holds addr 7; rd_src1=7 -> hazard=1. rd_src1=0 with in_valid, in_addr=0 -> hazard=0, and nothing is enqueued.
- Two pushes to addr 2 (values 0x11 then 0x22) -> rf writes 0x11 then 0x22. With RF_WB_FORWARD_EN, rd_src2=2 gives fwd2_data=0x22.
- Assert rst mid-drain with count=3 -> rf_we drops to 0 immediately, count=0, and no further writes occur after release.
